apb_regbank: RTL and testbench

APB_REGBANK -- requirements
Module: apb_regbank

---
 rtl/apb_regbank.sv | 163 ++++++++++++++++
 tb/tb_apb_regbank.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
// APB register bank with configurable wait states, byte strobes, read-only
// and privileged-write masks, and a saturating error counter.
module apb_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 16,
  parameter int                  NUM_WS     = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] PRIV_MASK  = '0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [7:0]              err_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BYTES);
  localparam int IW    = ADDR_WIDTH - ALIGN;
  localparam int SW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [IW:0]           REG_LIMIT  = (IW + 1)'(NUM_REGS);
  localparam logic [3:0]            WS_LOAD    = 4'(NUM_WS);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

  state_t                state;
  state_t                phase;
  state_t                next_state;
  logic [3:0]            ws_cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [BYTES-1:0]      cap_strb;
  logic                  cap_priv;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IW-1:0]         idx;
  logic [SW-1:0]         sel;
  logic                  misaligned;
  logic                  in_range;
  logic                  ro_hit;
  logic                  priv_hit;
  logic                  bad;
  logic                  unused_prot;

  assign unused_prot = ^pprot[2:1];

  assign idx        = cap_addr[ADDR_WIDTH-1:ALIGN];
  assign sel        = idx[SW-1:0];
  assign misaligned = (cap_addr & ALIGN_MASK) != '0;
  assign in_range   = {1'b0, idx} < REG_LIMIT;
  assign ro_hit     = in_range && RO_MASK[sel];
  assign priv_hit   = in_range && PRIV_MASK[sel];
  assign bad        = misaligned || !in_range
                    || (cap_write && (ro_hit || (priv_hit && !cap_priv)))
                    || (!cap_write && (cap_strb != '0));

  // SETUP lasts exactly the APB setup cycle, so it is decoded from the bus
  // on top of the registered state; this lets pready rise on the first access
  // cycle when there are no wait states. Outputs are zero unless completing.
  always_comb begin
    phase      = state;
    next_state = state;
    pready     = 1'b0;
    pslverr    = 1'b0;
    prdata     = '0;
    if ((state == IDLE || state == RESP) && psel && !penable) begin
      phase = SETUP;
    end
    case (phase)
      IDLE:  next_state = IDLE;
      SETUP: next_state = (NUM_WS == 0) ? RESP : WAIT;
      WAIT: begin
        if (!psel) begin
          next_state = IDLE;
        end else if (ws_cnt <= 4'd1) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        pready     = psel && penable;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (pready) begin
      pslverr = bad;
      if (!bad && !cap_write) begin
        prdata = regs[sel];
      end
    end
  end

  // State register and wait-state counter; an abandoned wait clears the count.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= IDLE;
      ws_cnt <= '0;
    end else begin
      state <= next_state;
      if (phase == SETUP) begin
        ws_cnt <= WS_LOAD;
      end else if (phase == WAIT && !psel) begin
        ws_cnt <= '0;
      end else if (phase == WAIT && ws_cnt != '0) begin
        ws_cnt <= ws_cnt - 4'd1;
      end
    end
  end

  // Latch the transfer attributes during the setup cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      cap_priv  <= 1'b0;
    end else if (phase == SETUP) begin
      cap_addr  <= paddr;
      cap_write <= pwrite;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
      cap_priv  <= pprot[0];
    end
  end

  // Commit strobed byte lanes of a good write on its completing edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (pready && !bad && cap_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cap_strb[b]) begin
          regs[sel][8*b +: 8] <= cap_wdata[8*b +: 8];
        end
      end
    end
  end

  // Count completed errored transfers, holding at 255.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_count <= '0;
    end else if (pready && bad && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_regbank.sv
// Directed bench for apb_regbank: three instances with 0, 2 and 3 wait
// states share one bus, each selected by its own psel bit.
module tb_apb_regbank;

  logic        pclk;
  logic        presetn;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [31:0] prdata_w    [3];
  logic        pready_w    [3];
  logic        pslverr_w   [3];
  logic [7:0]  err_count_w [3];

  int          cur;
  logic        rdy;
  logic        slv;
  logic [31:0] prd;

  int n_checks;
  int n_bad;

  apb_regbank #(.NUM_WS(0)) dut_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_w[0]), .pready(pready_w[0]),
    .pslverr(pslverr_w[0]), .err_count(err_count_w[0])
  );

  apb_regbank #(.NUM_WS(2), .RO_MASK(16'h0002), .PRIV_MASK(16'h0008)) dut_ws2 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_w[1]), .pready(pready_w[1]),
    .pslverr(pslverr_w[1]), .err_count(err_count_w[1])
  );

  apb_regbank #(.NUM_WS(3)) dut_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_w[2]), .pready(pready_w[2]),
    .pslverr(pslverr_w[2]), .err_count(err_count_w[2])
  );

  // Free-running 10 ns clock.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Route the currently addressed instance's outputs to common names.
  always_comb begin
    rdy = 1'b0;
    slv = 1'b0;
    prd = '0;
    case (cur)
      0: begin rdy = pready_w[0]; slv = pslverr_w[0]; prd = prdata_w[0]; end
      1: begin rdy = pready_w[1]; slv = pslverr_w[1]; prd = prdata_w[1]; end
      2: begin rdy = pready_w[2]; slv = pslverr_w[2]; prd = prdata_w[2]; end
      default: begin rdy = 1'b0; slv = 1'b0; prd = '0; end
    endcase
  end

  task automatic apb_xfer(input int which, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [31:0] rdata,
                          output logic err, output int waits);
    cur = which;
    @(negedge pclk);
    psel_v         = '0;
    psel_v[which]  = 1'b1;
    penable        = 1'b0;
    pwrite         = wr;
    paddr          = addr;
    pwdata         = wdata;
    pstrb          = strb;
    pprot          = prot;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (rdy !== 1'b1 && waits < 20) begin
      n_checks++;
      if (prd !== 32'h0 || slv !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL wait_outputs addr=%h: prdata=%h pslverr=%b, want 0/0", addr, prd, slv);
      end
      @(negedge pclk);
      #1;
      waits++;
    end
    if (waits >= 20) begin
      n_checks++;
      n_bad++;
      $display("[TB] FAIL pready_timeout addr=%h: no pready within 20 cycles", addr);
    end
    rdata = prd;
    err   = slv;
    @(negedge pclk);
    psel_v  = '0;
    penable = 1'b0;
    pstrb   = '0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    psel_v  = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    cur     = 0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pready_w[i] !== 1'b0 || pslverr_w[i] !== 1'b0 || prdata_w[i] !== 32'h0
          || err_count_w[i] !== 8'h0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h err=%0d, want all 0",
                 i, pready_w[i], pslverr_w[i], prdata_w[i], err_count_w[i]);
      end
    end
    presetn = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w);
    n_checks++;
    if (er !== 1'b0 || w != 0) begin
      n_bad++;
      $display("[TB] FAIL write_04: pslverr=%b waits=%0d, want 0/0", er, w);
    end
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || w != 0) begin
      n_bad++;
      $display("[TB] FAIL read_04: prdata=%h pslverr=%b waits=%0d, want DEADBEEF/0/0", rd, er, w);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(2, 1'b0, 8'h00, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (w != 3 || rd !== 32'h0 || er !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ws3_read: waits=%0d prdata=%h pslverr=%b, want 3/00000000/0", w, rd, er);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 3'b000, rd, er, w);
    apb_xfer(0, 1'b1, 8'h08, 32'h11223344, 4'h5, 3'b000, rd, er, w);
    n_checks++;
    if (er !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL strobe_write: pslverr=%b, want 0", er);
    end
    apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'hAA22CC44) begin
      n_bad++;
      $display("[TB] FAIL strobe_merge: prdata=%h, want AA22CC44", rd);
    end
  endtask

  task automatic test_back_to_back();
    cur = 0;
    @(negedge pclk);
    psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h0C; pwdata = 32'h55AA55AA; pstrb = 4'hF; pprot = 3'b000;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    n_checks++;
    if (rdy !== 1'b1 || slv !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL b2b_write: pready=%b pslverr=%b, want 1/0", rdy, slv);
    end
    @(negedge pclk);
    penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    n_checks++;
    if (rdy !== 1'b1 || prd !== 32'h55AA55AA) begin
      n_bad++;
      $display("[TB] FAIL b2b_read: pready=%b prdata=%h, want 1/55AA55AA", rdy, prd);
    end
    @(negedge pclk);
    psel_v = '0; penable = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(1, 1'b0, 8'h02, 32'h0, 4'h0, 3'b001, rd, er, w);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || w != 2) begin
      n_bad++;
      $display("[TB] FAIL err_misaligned: pslverr=%b prdata=%h waits=%0d, want 1/0/2", er, rd, w);
    end
    apb_xfer(1, 1'b1, 8'h40, 32'h12345678, 4'hF, 3'b001, rd, er, w);
    n_checks++;
    if (er !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL err_range: pslverr=%b, want 1", er);
    end
    apb_xfer(1, 1'b1, 8'h04, 32'h12345678, 4'hF, 3'b001, rd, er, w);
    n_checks++;
    if (er !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL err_readonly: pslverr=%b, want 1", er);
    end
    apb_xfer(1, 1'b1, 8'h0C, 32'h12345678, 4'hF, 3'b000, rd, er, w);
    n_checks++;
    if (er !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL err_unpriv: pslverr=%b, want 1", er);
    end
    n_checks++;
    if (err_count_w[1] !== 8'd4) begin
      n_bad++;
      $display("[TB] FAIL err_count4: err_count=%0d, want 4", err_count_w[1]);
    end
    apb_xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ro_unchanged: prdata=%h pslverr=%b, want 0/0", rd, er);
    end
    apb_xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL priv_unchanged: prdata=%h, want 0", rd);
    end
    apb_xfer(1, 1'b1, 8'h0C, 32'h0000BEEF, 4'hF, 3'b001, rd, er, w);
    apb_xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'h0000BEEF || er !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL priv_write: prdata=%h pslverr=%b, want 0000BEEF/0", rd, er);
    end
    apb_xfer(1, 1'b1, 8'h18, 32'hFFFFFFFF, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (er !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL zero_strb_err: pslverr=%b, want 0", er);
    end
    apb_xfer(1, 1'b0, 8'h18, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'h0 || err_count_w[1] !== 8'd4) begin
      n_bad++;
      $display("[TB] FAIL zero_strb_data: prdata=%h err_count=%0d, want 0/4", rd, err_count_w[1]);
    end
    apb_xfer(1, 1'b0, 8'h18, 32'h0, 4'h3, 3'b000, rd, er, w);
    n_checks++;
    if (er !== 1'b1 || err_count_w[1] !== 8'd5) begin
      n_bad++;
      $display("[TB] FAIL read_strb: pslverr=%b err_count=%0d, want 1/5", er, err_count_w[1]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(1, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, w);
    cur = 1;
    @(negedge pclk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h10; pwdata = 32'h0BADBEEF; pstrb = 4'hF; pprot = 3'b000;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel_v = '0; penable = 1'b0;
    apb_xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, 3'b000, rd, er, w);
    n_checks++;
    if (rd !== 32'hCAFEF00D || err_count_w[1] !== 8'd5) begin
      n_bad++;
      $display("[TB] FAIL abort: prdata=%h err_count=%0d, want CAFEF00D/5", rd, err_count_w[1]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    logic        er;
    int          w;
    for (int k = 0; k < 260; k++) begin
      apb_xfer(0, 1'b0, 8'h01, 32'h0, 4'h0, 3'b000, rd, er, w);
    end
    n_checks++;
    if (err_count_w[0] !== 8'd255) begin
      n_bad++;
      $display("[TB] FAIL err_saturate: err_count=%0d, want 255", err_count_w[0]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(1, 1'b1, 8'h14, 32'h12345678, 4'hF, 3'b000, rd, er, w);
    cur = 1;
    @(negedge pclk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h14; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    presetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (pready_w[1] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_pready cycle %0d: pready=%b, want 0", c, pready_w[1]);
      end
      @(negedge pclk);
    end
    psel_v = '0; penable = 1'b0;
    presetn = 1'b1;
    for (int r = 0; r < 16; r++) begin
      apb_xfer(1, 1'b0, 8'(r * 4), 32'h0, 4'h0, 3'b000, rd, er, w);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL post_reset_reg%0d: prdata=%h pslverr=%b, want 0/0", r, rd, er);
      end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    n_checks = 0;
    n_bad    = 0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_strobe();
    test_back_to_back();
    test_errors();
    test_abort();
    test_saturation();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
